// File: rtl/icache_fill_ctl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctl
//
// Line-fill sequencer between the instruction cache and the nibble-serial
// external memory port. On a miss it requests the line, collects
// 2*LINE_LENGTH nibbles into a local buffer (absorbing gaps on the memory
// side), and then writes the whole line into the icache as one gap-free
// burst of strobes. The icache clears its write offset on any idle cycle,
// so the burst must not be interrupted.
//
// Optional feature macro: FILL_TIMEOUT_EN
//   defined   : a watchdog abandons the fill (fill_err pulse) after TIMEOUT
//               COLLECT cycles with no mem_valid since the grant or the
//               last nibble.
//   undefined : COLLECT waits indefinitely; TIMEOUT has no effect.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset (0 = reset)
//   ic_pull       in   icache miss on current fetch address
//   ic_tag        in   line address of the miss
//   ic_fault      in   fetch address faults; do not fill
//   ic_wstrobe_d  out  nibble write strobe to icache
//   ic_dread      out  nibble data to icache
//   ic_hold       out  freeze fetch address while a fill is in progress
//   fill_err      out  one-cycle pulse, fill abandoned
//   mem_req       out  memory line-read request
//   mem_addr      out  line byte address {ic_tag, zero offset}
//   mem_gnt       in   one-cycle pulse, request accepted
//   mem_valid     in   mem_data carries the next nibble
//   mem_data      in   read nibble, nibble 0 of the line first
//   mem_err       in   memory error, abandon the line
// -----------------------------------------------------------------------------
module icache_fill_ctl #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22,
    parameter int TIMEOUT     = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ic_pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]  ic_tag,
    input  logic                               ic_fault,
    output logic                               ic_wstrobe_d,
    output logic [3:0]                         ic_dread,
    output logic                               ic_hold,
    output logic                               fill_err,
    output logic                               mem_req,
    output logic [PA-1:0]                      mem_addr,
    input  logic                               mem_gnt,
    input  logic                               mem_valid,
    input  logic [3:0]                         mem_data,
    input  logic                               mem_err
);

    localparam int NNIB = 2 * LINE_LENGTH;
    localparam int OFF  = $clog2(LINE_LENGTH);
    localparam int CW   = $clog2(NNIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NNIB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_BURST,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PA-1:0]   addr_reg, addr_next;
    logic            capture;

    logic            mem_req_reg;
    logic            hold_reg;
    logic            err_reg;
    logic            wstrobe_reg;
    logic [3:0]      dread_reg;

    // Line buffer; written during COLLECT, read through dread_reg in BURST.
    logic [3:0]      line_buf [NNIB];

`ifdef FILL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0]   wd_reg, wd_next;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        capture    = 1'b0;
`ifdef FILL_TIMEOUT_EN
        wd_next    = wd_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // A faulting fetch address never reaches the memory port.
                if (ic_pull && !ic_fault) begin
                    addr_next  = {ic_tag, {OFF{1'b0}}};
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_err) begin
                    state_next = S_ERR;
                end else if (mem_gnt) begin
                    state_next = S_COLLECT;
                    cnt_next   = '0;
`ifdef FILL_TIMEOUT_EN
                    wd_next    = '0;
`endif
                end
            end
            S_COLLECT: begin
                // mem_err wins over a nibble arriving in the same cycle.
                if (mem_err) begin
                    state_next = S_ERR;
                end else if (mem_valid) begin
                    capture = 1'b1;
`ifdef FILL_TIMEOUT_EN
                    wd_next = '0;
`endif
                    if (cnt_reg == CNT_LAST) begin
                        state_next = S_BURST;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
`ifdef FILL_TIMEOUT_EN
                else if (wd_reg == WD_LAST) begin
                    state_next = S_ERR;
                end else begin
                    wd_next = wd_reg + WW'(1);
                end
`endif
            end
            S_BURST: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;  // guard cycle, ic_pull ignored
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State and registered outputs. Outputs are decoded from state_next so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            mem_req_reg <= 1'b0;
            hold_reg    <= 1'b0;
            err_reg     <= 1'b0;
            wstrobe_reg <= 1'b0;
            dread_reg   <= '0;
`ifdef FILL_TIMEOUT_EN
            wd_reg      <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            mem_req_reg <= (state_next == S_REQ) || (state_next == S_COLLECT);
            hold_reg    <= (state_next != S_IDLE);
            err_reg     <= (state_next == S_ERR);
            wstrobe_reg <= (state_next == S_BURST);
            // Registered buffer read: nibble cnt_next is presented in the
            // same cycle its strobe is high.
            dread_reg   <= (state_next == S_BURST) ? line_buf[cnt_next] : 4'h0;
`ifdef FILL_TIMEOUT_EN
            wd_reg      <= wd_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            line_buf[cnt_reg] <= mem_data;
        end
    end

    assign ic_wstrobe_d = wstrobe_reg;
    assign ic_dread     = dread_reg;
    assign ic_hold      = hold_reg;
    assign fill_err     = err_reg;
    assign mem_req      = mem_req_reg;
    assign mem_addr     = addr_reg;

endmodule

// File: tb/tb_icache_fill_ctl.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_ctl
//
// Directed bench for icache_fill_ctl. Nibbles are pushed to a scoreboard
// queue as they are driven on the memory port; a negedge monitor pops and
// compares one entry per icache strobe and measures burst lengths.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctl;

    localparam int LL = 4;
    localparam int PA = 22;
    localparam int TW = PA - 2;

    logic           clk;
    logic           reset;
    logic           ic_pull;
    logic [TW-1:0]  ic_tag;
    logic           ic_fault;
    logic           ic_wstrobe_d;
    logic [3:0]     ic_dread;
    logic           ic_hold;
    logic           fill_err;
    logic           mem_req;
    logic [PA-1:0]  mem_addr;
    logic           mem_gnt;
    logic           mem_valid;
    logic [3:0]     mem_data;
    logic           mem_err;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] sb [$];
    int run_len        = 0;
    int last_burst_len = 0;
    int strobe_total   = 0;

    icache_fill_ctl #(
        .LINE_LENGTH (LL),
        .PA          (PA),
        .TIMEOUT     (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ic_pull      (ic_pull),
        .ic_tag       (ic_tag),
        .ic_fault     (ic_fault),
        .ic_wstrobe_d (ic_wstrobe_d),
        .ic_dread     (ic_dread),
        .ic_hold      (ic_hold),
        .fill_err     (fill_err),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .mem_err      (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish within bound");
        $fatal(1, "simulation bound expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe monitor: one scoreboard pop per strobe, burst length on fall.
    always @(negedge clk) begin
        logic [4:0] exp5;
        if (ic_wstrobe_d) begin
            strobe_total++;
            run_len++;
            if (sb.size() > 0) exp5 = {1'b0, sb.pop_front()};
            else               exp5 = 5'h10;
            check("strobe_data", {27'd0, 1'b0, ic_dread}, {27'd0, exp5});
            $display("strobe beat %0d: dread=%0h", run_len, ic_dread);
        end else if (run_len != 0) begin
            last_burst_len = run_len;
            run_len = 0;
        end
    end

    task automatic do_miss(input logic [TW-1:0] tag);
        ic_tag  = tag;
        ic_pull = 1'b1;
        tick();
        check("miss_req",  mem_req, 1);
        check("miss_hold", ic_hold, 1);
        check("miss_addr", mem_addr, {tag, 2'b00});
        $display("miss tag=%0h mem_addr=%0h", tag, mem_addr);
    endtask

    task automatic grant();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] d, input int gap);
        repeat (gap) tick();
        mem_valid = 1'b1;
        mem_data  = d;
        sb.push_back(d);
        tick();
        mem_valid = 1'b0;
    endtask

    // Called right after the last capture edge.
    task automatic finish_fill(input string tag);
        check({tag, "_first_strobe"}, ic_wstrobe_d, 1);
        check({tag, "_req_drop"},     mem_req, 0);
        repeat (8) tick();
        check({tag, "_strobe_end"},   ic_wstrobe_d, 0);
        check({tag, "_done_hold"},    ic_hold, 1);
        ic_pull = 1'b0;
        tick();
        check({tag, "_hold_drop"},    ic_hold, 0);
        check({tag, "_idle_req"},     mem_req, 0);
        check({tag, "_burst_len"},    last_burst_len, 8);
        check({tag, "_sb_empty"},     sb.size(), 0);
        $display("fill %s complete, burst length %0d", tag, last_burst_len);
    endtask

    initial begin
        int s0;
        int n;
        logic seen_err;

        reset     = 1'b0;
        ic_pull   = 1'b0;
        ic_tag    = '0;
        ic_fault  = 1'b0;
        mem_gnt   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = 4'h0;
        mem_err   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req",    mem_req, 0);
        check("rst_hold",   ic_hold, 0);
        check("rst_strobe", ic_wstrobe_d, 0);
        check("rst_err",    fill_err, 0);
        check("rst_addr",   mem_addr, 0);
        check("rst_dread",  ic_dread, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: back-to-back fill; a stray mem_valid during REQ must be ignored.
        do_miss(20'h12345);
        check("t1_addr_const", mem_addr, 22'h48D14);
        mem_valid = 1'b1;
        mem_data  = 4'hF;
        tick();
        mem_valid = 1'b0;
        check("t1_req_wait", mem_req, 1);
        grant();
        for (int i = 0; i < 8; i++) send_nib(4'(i), 0);
        finish_fill("t1");

        // 2: gaps between nibbles never reach the icache.
        do_miss(20'h00F0F);
        ic_pull = 1'b0;
        grant();
        for (int i = 0; i < 8; i++) send_nib(4'($urandom_range(0, 15)), $urandom_range(1, 3));
        finish_fill("t2");

        // 3: faulting miss never requests.
        ic_fault = 1'b1;
        ic_pull  = 1'b1;
        ic_tag   = 20'h0BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_no_req",  mem_req, 0);
            check("t3_no_hold", ic_hold, 0);
        end
        ic_pull  = 1'b0;
        ic_fault = 1'b0;
        tick();

        // 4: mem_err together with the 5th nibble.
        s0 = strobe_total;
        do_miss(20'h3C3C3);
        ic_pull = 1'b0;
        grant();
        for (int i = 0; i < 4; i++) send_nib(4'(i + 8), 0);
        mem_valid = 1'b1;
        mem_data  = 4'h4;
        mem_err   = 1'b1;
        tick();
        mem_valid = 1'b0;
        mem_err   = 1'b0;
        check("t4_err_pulse", fill_err, 1);
        check("t4_req_drop",  mem_req, 0);
        check("t4_no_strobe", ic_wstrobe_d, 0);
        check("t4_err_hold",  ic_hold, 1);
        tick();
        check("t4_err_end",   fill_err, 0);
        check("t4_hold_drop", ic_hold, 0);
        repeat (3) tick();
        check("t4_strobe_cnt", strobe_total, s0);
        sb.delete();
        $display("error fill abandoned");
        do_miss(20'h0ABCD);
        ic_pull = 1'b0;
        grant();
        for (int i = 0; i < 8; i++) send_nib(4'(15 - i), 0);
        finish_fill("t4b");

        // 5: reset in the 3rd burst cycle.
        do_miss(20'h11111);
        ic_pull = 1'b0;
        grant();
        for (int i = 0; i < 8; i++) send_nib(4'(i + 3), 0);
        tick();
        tick();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5_strobe_off", ic_wstrobe_d, 0);
        check("t5_hold_off",   ic_hold, 0);
        check("t5_req_off",    mem_req, 0);
        check("t5_addr_off",   mem_addr, 0);
        check("t5_dread_off",  ic_dread, 0);
        repeat (2) tick();
        check("t5_partial_len", last_burst_len, 3);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("t5_post_hold", ic_hold, 0);
        do_miss(20'h11111);
        ic_pull = 1'b0;
        grant();
        for (int i = 0; i < 8; i++) send_nib(4'(i + 3), 0);
        finish_fill("t5b");

        // 6: stall after nibble 2.
        do_miss(20'h22222);
        ic_pull = 1'b0;
        grant();
        for (int i = 0; i < 3; i++) send_nib(4'(i + 5), 0);
`ifdef FILL_TIMEOUT_EN
        n = 0;
        while (!fill_err && n < 200) begin
            tick();
            n++;
        end
        check("t6_timeout_cycles", n, 64);
        check("t6_req_drop", mem_req, 0);
        tick();
        check("t6_hold_drop", ic_hold, 0);
        sb.delete();
        $display("watchdog fired after %0d cycles", n);
`else
        n = 0;
        seen_err = 1'b0;
        repeat (100) begin
            tick();
            n++;
            if (fill_err) seen_err = 1'b1;
        end
        check("t6_no_err",   seen_err, 0);
        check("t6_req_held", mem_req, 1);
        check("t6_hold",     ic_hold, 1);
        $display("stall of %0d cycles tolerated", n);
        for (int i = 3; i < 8; i++) send_nib(4'(i + 5), 0);
        finish_fill("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
